boot_loader_ctrl: RTL

Sequences firmware loading into the core's dual-port RAM from a byte stream (UART/SPI receiver), then releases the core from reset. It sits between the byte-stream source, RAM write port A and the `rst_n` input of `riscv_core`, replacing bench-side backdoor RAM loading in silicon builds. Stream format: 32-bit little-endian word count N, then N little-endian 32-bit words, stored at consecutive word addresses from `BASE_ADDR`.

---
 rtl/boot_pkg.sv | 15 +
 rtl/byte_packer.sv | 38 +++
 rtl/boot_loader_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the firmware boot loader.
package boot_pkg;

    localparam int BOOT_HDR_BYTES = 4;
    localparam int BOOT_WORD_W    = 32;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } boot_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid pulses combinationally
// with the 4th accepted byte, and the stream stalls whenever the owner drops i_ready.
module byte_packer
    import boot_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    input  logic                   i_ready,
    output logic                   o_word_valid,
    output logic [BOOT_WORD_W-1:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_lo;
    logic        w_acc;

    assign w_acc        = i_valid & i_ready;
    assign o_word_valid = w_acc && (r_idx == 2'(BOOT_HDR_BYTES - 1));
    assign o_word       = {i_data, r_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
            r_lo  <= 24'd0;
        end else if (w_acc) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_lo[7:0]   <= i_data;
                2'd1:    r_lo[15:8]  <= i_data;
                2'd2:    r_lo[23:16] <= i_data;
                default: r_lo        <= r_lo;
            endcase
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Streams a length-prefixed firmware image into RAM port A, then releases the core from reset.
// Optional trailing checksum word is compiled in with BOOT_CHECKSUM_EN.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   mem_we,
    output logic [ADDR_W+1:0]      mem_addr,
    output logic [BOOT_WORD_W-1:0] mem_wdata,
    output logic                   core_rst_n,
    output logic                   boot_done,
    output logic                   boot_err
);

    localparam logic [32:0]       LEN_MAX = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR >> 2));
    localparam logic [ADDR_W+1:0] BASE_A  = (ADDR_W + 2)'(BASE_ADDR);

    boot_state_t            r_state;
    logic [ADDR_W:0]        r_n;
    logic [ADDR_W:0]        r_cnt;
    logic [ADDR_W+1:0]      r_addr;
    logic                   r_pend;
    logic                   r_we;
    logic [ADDR_W+1:0]      r_mem_addr;
    logic [BOOT_WORD_W-1:0] r_wdata;
    logic                   r_core_rst_n;
    logic                   r_done;
    logic                   r_err;
`ifdef BOOT_CHECKSUM_EN
    logic [BOOT_WORD_W-1:0] r_sum;
`endif

    logic                   w_word_vld;
    logic [BOOT_WORD_W-1:0] w_word;
    logic                   w_in_rx;
    logic [ADDR_W:0]        w_cnt_nxt;
    logic                   w_len_bad;

    // r_pend closes the stream during the final write so no stray byte is swallowed.
    assign w_in_rx   = ((r_state == ST_HDR) || (r_state == ST_LOAD) || (r_state == ST_CHK)) && !r_pend;
    assign rx_ready  = rst_n & w_in_rx;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_len_bad = {1'b0, w_word} > LEN_MAX;

    assign mem_we     = r_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_wdata;
    assign core_rst_n = r_core_rst_n;
    assign boot_done  = r_done;
    assign boot_err   = r_err;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (rx_data),
        .i_valid      (rx_valid),
        .i_ready      (rx_ready),
        .o_word_valid (w_word_vld),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HDR;
            r_n          <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_pend       <= 1'b0;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_word_vld) begin
                        if (w_word == '0) begin
`ifdef BOOT_CHECKSUM_EN
                            r_state      <= ST_CHK;
`else
                            r_state      <= ST_RUN;
                            r_core_rst_n <= 1'b1;
                            r_done       <= 1'b1;
`endif
                        end else if (w_len_bad) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_n     <= w_word[ADDR_W:0];
                            r_cnt   <= '0;
                            r_addr  <= BASE_A;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (r_pend) begin
                        r_pend       <= 1'b0;
                        r_state      <= ST_RUN;
                        r_core_rst_n <= 1'b1;
                        r_done       <= 1'b1;
                    end else if (w_word_vld) begin
                        r_we       <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_wdata    <= w_word;
                        r_addr     <= r_addr + (ADDR_W + 2)'(4);
                        r_cnt      <= w_cnt_nxt;
`ifdef BOOT_CHECKSUM_EN
                        r_sum      <= r_sum + w_word;
                        if (w_cnt_nxt == r_n) r_state <= ST_CHK;
`else
                        if (w_cnt_nxt == r_n) r_pend <= 1'b1;
`endif
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CHK: begin
                    if (w_word_vld) begin
                        if (w_word == r_sum) begin
                            r_state      <= ST_RUN;
                            r_core_rst_n <= 1'b1;
                            r_done       <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                ST_RUN:  r_state <= ST_RUN;
                ST_ERR:  r_state <= ST_ERR;
                default: begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

endmodule
